// File: rtl/mips_mem_pkg.sv
// Shared encodings for the CPU-side memory access unit: access sizes, FSM states,
// the captured request payload and the request fault rule.
package mips_mem_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 500;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned ADDR_W            = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } mau_state_e;

    typedef struct packed {
        logic              write;
        mem_size_e         size;
        logic              is_unsigned;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Reserved size, misalignment for the access width, or a word index past the end of memory.
    function automatic logic req_fault(input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                                       input int unsigned words);
        logic misaligned;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = |addr[1:0];
            default:   misaligned = 1'b1;
        endcase
        return misaligned || (32'(addr[ADDR_W-1:2]) >= words);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts/extends a sub-word load and merges a sub-word
// store into the word read back from memory.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_offset,
    input  mem_size_e         i_size,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_c,
    output logic [DATA_W-1:0] o_merge_c
);

    logic [4:0]  w_bshift;
    logic [4:0]  w_hshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
    always_comb begin
        w_bshift  = {~i_offset, 3'b000};
        w_hshift  = {~i_offset[1], 4'b0000};
        w_byte    = 8'(i_word >> w_bshift);
        w_half    = 16'(i_word >> w_hshift);
        o_load_c  = '0;
        o_merge_c = i_word;
        case (i_size)
            SIZE_BYTE: begin
                o_load_c  = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merge_c = (i_word & ~(32'h0000_00FF << w_bshift))
                          | ({24'h0, i_wdata[7:0]} << w_bshift);
            end
            SIZE_HALF: begin
                o_load_c  = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_merge_c = (i_word & ~(32'h0000_FFFF << w_hshift))
                          | ({16'h0, i_wdata[15:0]} << w_hshift);
            end
            SIZE_WORD: begin
                o_load_c  = i_word;
                o_merge_c = i_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store front end for a word-addressed memory: checks faults, sequences
// read / write / read-modify-write accesses and returns a one-cycle response.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] MemData
);

    mau_state_e        r_state;
    mem_req_t          r_req;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_fault;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    always_comb begin
        w_accept = req_valid && r_req_ready;
        w_fault  = req_fault(req_size, req_addr, MEM_WORDS);
    end

    mem_lane_align u_lane_align (
        .i_word     (MemData),
        .i_offset   (r_req.addr[1:0]),
        .i_size     (r_req.size),
        .i_unsigned (r_req.is_unsigned),
        .i_wdata    (r_req.wdata),
        .o_load_c   (w_load),
        .o_merge_c  (w_merge)
    );

    // Strobes and response flags default low each cycle; only the state that needs them raises them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req       <= '{write: req_write, size: mem_size_e'(req_size),
                                         is_unsigned: req_unsigned, addr: req_addr,
                                         wdata: req_wdata};
                        r_req_ready <= 1'b0;
                        if (w_fault) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            r_state     <= WRITE;
                            r_mem_write <= 1'b1;
                            r_wdata     <= req_wdata;
                        end else begin
                            r_state    <= READ;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (r_req.write) begin
                        r_state     <= WRITE;
                        r_mem_write <= 1'b1;
                        r_wdata     <= w_merge;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end
                end
                WRITE: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = r_req_ready;
        resp_valid = r_resp_valid;
        resp_fault = r_resp_fault;
        resp_rdata = r_resp_rdata;
        MemRead    = r_mem_read;
        MemWrite   = r_mem_write;
        Address    = 32'(r_req.addr[ADDR_W-1:2]);
        WriteData  = r_wdata;
    end

endmodule
